// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed signed FIR with one multiply-accumulate per cycle.
// Samples enter through a valid/ready handshake and shift into an NTAP-deep
// delay line. The FSM then walks the taps, accumulating x[k]*c[k]. It presents
// the sum on a valid/ready output handshake.
//
// Ports:
//   clk        rising-edge clock
//   rstn       synchronous active-low reset
//   coef_we    coefficient write strobe (honoured only while idle)
//   coef_addr  tap index for the coefficient write
//   coef_data  signed coefficient value
//   in_valid   sample offered
//   in_ready   block can accept a sample (high only while idle)
//   in_data    signed sample
//   out_valid  result available
//   out_ready  downstream accepts the result
//   out_data   signed filtered result
//   busy       computation in progress or result pending
module fir_mac_seq #(
    parameter int unsigned NTAP = 8,
    parameter int unsigned DW   = 8,
    parameter int unsigned CW   = 8,
    parameter int unsigned AW   = 3,
    parameter int unsigned ACCW = 19
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   coef_we,
    input  logic [AW-1:0]          coef_addr,
    input  logic signed [CW-1:0]   coef_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DW-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [ACCW-1:0] out_data,
    output logic                   busy
);

    localparam int unsigned PW = DW + CW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic signed [DW-1:0]   x [NTAP];
    logic signed [CW-1:0]   c [NTAP];
    logic signed [ACCW-1:0] acc;
    logic [AW-1:0]          k;

    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] sum;

    // Full-width signed product of the current tap, sign-extended into the accumulator.
    assign prod = PW'(x[k]) * PW'(c[k]);
    assign sum  = acc + ACCW'(prod);

    // Handshake and status flags decode directly from the state register.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Control FSM, delay line, coefficient store and accumulator.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            acc       <= '0;
            k         <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < int'(NTAP); i++) begin
                x[i] <= '0;
                c[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A coefficient write may coincide with a sample accept; the
                    // new value is visible because MAC starts on the next cycle.
                    if (coef_we) begin
                        c[coef_addr] <= coef_data;
                    end
                    if (in_valid) begin
                        for (int i = 1; i < int'(NTAP); i++) begin
                            x[i] <= x[i-1];
                        end
                        x[0]  <= in_data;
                        acc   <= '0;
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= sum;
                    k   <= k + AW'(1);
                    if (k == AW'(NTAP - 1)) begin
                        out_data  <= sum;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Result held until downstream takes it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq. A reference model of the
// coefficients and delay line pushes expected results into a queue when a
// sample is accepted. Each scenario task pops the queue and compares.
module tb_fir_mac_seq;

    logic               clk;
    logic               rstn;
    logic               coef_we;
    logic [2:0]         coef_addr;
    logic signed [7:0]  coef_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [18:0] out_data;
    logic               busy;

    fir_mac_seq dut (
        .clk       (clk),
        .rstn      (rstn),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int mc [8];
    int mx [8];
    int sb [$];

    function automatic int model_y();
        int s = 0;
        for (int i = 0; i < 8; i++) s += mc[i] * mx[i];
        return s;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) begin
            mc[i] = 0;
            mx[i] = 0;
        end
        sb.delete();
    endfunction

    function automatic void model_accept(input int d);
        for (int i = 7; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = d;
        sb.push_back(model_y());
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        model_clear();
    endtask

    // Write one coefficient while idle; the model follows.
    task automatic write_coef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 3'(a);
        coef_data = 8'(d);
        mc[a]     = d;
        tick();
        coef_we = 1'b0;
    endtask

    // Offer a sample, wait (bounded) for in_ready, model the accept edge.
    task automatic send(input int d);
        int n = 0;
        in_data  = 8'(d);
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        model_accept(d);
        tick();
        in_valid = 1'b0;
    endtask

    // Bounded wait for out_valid; consumes the result when out_ready is high.
    task automatic wait_out(output logic [18:0] d, output int cyc, output bit ok);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        ok = (out_valid === 1'b1);
        d  = out_data;
        if (ok && out_ready === 1'b1) tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (out_valid !== 1'b0 || out_data !== 19'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset: valid=%b data=%0d ready=%b busy=%b, want 0 0 1 0",
                     out_valid, out_data, in_ready, busy);
        end
    endtask

    task automatic test_impulse();
        logic [18:0] d;
        int cyc, e;
        bit ok;
        do_reset();
        for (int i = 0; i < 8; i++) write_coef(i, i + 1);
        for (int n = 0; n < 9; n++) begin
            send(n == 0 ? 1 : 0);
            wait_out(d, cyc, ok);
            e = (sb.size() > 0) ? sb.pop_front() : -999;
            total++;
            if (!ok || d !== 19'(e)) begin
                bad++;
                $display("FAIL impulse[%0d]: got %0d (valid=%b), want %0d", n, $signed(d), ok, e);
            end
            if (n == 0) begin
                total++;
                if (cyc !== 8) begin
                    bad++;
                    $display("FAIL impulse_latency: got %0d cycles, want 8", cyc);
                end
            end
        end
    endtask

    task automatic test_extreme();
        logic [18:0] d;
        int cyc, e;
        bit ok;
        do_reset();
        for (int i = 0; i < 8; i++) write_coef(i, -128);
        for (int n = 1; n <= 8; n++) begin
            send(-128);
            wait_out(d, cyc, ok);
            e = (sb.size() > 0) ? sb.pop_front() : -999;
            total++;
            if (!ok || d !== 19'(e) || e != 16384 * n) begin
                bad++;
                $display("FAIL extreme[%0d]: got %0d, want %0d", n, $signed(d), 16384 * n);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [18:0] d;
        int cyc, e, errs;
        bit ok;
        do_reset();
        for (int i = 0; i < 8; i++) write_coef(i, i + 1);
        out_ready = 1'b0;
        send(3);
        wait_out(d, cyc, ok);
        e = (sb.size() > 0) ? sb.pop_front() : -999;
        total++;
        if (!ok || d !== 19'(e)) begin
            bad++;
            $display("FAIL bp_result: got %0d, want %0d", $signed(d), e);
        end
        in_data  = 8'sd9;
        in_valid = 1'b1;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== 19'(e) || in_ready !== 1'b0 || busy !== 1'b1) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL bp_stall: %0d bad cycles, want 0 (valid=%b data=%0d ready=%b)",
                     errs, out_valid, $signed(out_data), in_ready);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
        send(9);
        wait_out(d, cyc, ok);
        e = (sb.size() > 0) ? sb.pop_front() : -999;
        total++;
        if (!ok || d !== 19'(e)) begin
            bad++;
            $display("FAIL bp_held_sample: got %0d, want %0d", $signed(d), e);
        end
    endtask

    task automatic test_coef_busy();
        logic [18:0] d;
        int cyc, e;
        bit ok;
        do_reset();
        write_coef(0, 3);
        write_coef(1, 2);
        send(5);
        // Write attempted during MAC: must be ignored, so the model is untouched.
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = -8'sd1;
        tick();
        coef_we = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (n == 1) send(0);
            if (n == 2) send(1);
            wait_out(d, cyc, ok);
            e = (sb.size() > 0) ? sb.pop_front() : -999;
            total++;
            if (!ok || d !== 19'(e)) begin
                bad++;
                $display("FAIL coef_busy[%0d]: got %0d, want %0d", n, $signed(d), e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [18:0] d;
        int cyc, e, errs;
        bit ok;
        do_reset();
        for (int i = 0; i < 8; i++) write_coef(i, i + 1);
        send(1);
        tick();
        tick();
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        model_clear();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: valid=%b ready=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
        end
        errs = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL reset_mid_quiet: %0d cycles with out_valid, want 0", errs);
        end
        for (int n = 0; n < 3; n++) begin
            send(n == 0 ? 1 : 0);
            wait_out(d, cyc, ok);
            e = (sb.size() > 0) ? sb.pop_front() : -999;
            total++;
            if (!ok || d !== 19'(e)) begin
                bad++;
                $display("FAIL reset_mid_impulse[%0d]: got %0d, want %0d", n, $signed(d), e);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [18:0] d;
        int cyc, e;
        bit ok;
        do_reset();
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 8'sd7;
        mc[0]     = 7;
        send(2);
        coef_we = 1'b0;
        wait_out(d, cyc, ok);
        e = (sb.size() > 0) ? sb.pop_front() : -999;
        total++;
        if (!ok || d !== 19'(e) || e != 14) begin
            bad++;
            $display("FAIL simultaneous: got %0d, want 14", $signed(d));
        end
    endtask

    initial begin
        rstn      = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        model_clear();
        test_reset();
        test_impulse();
        test_extreme();
        test_backpressure();
        test_coef_busy();
        test_reset_mid();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
